// File: rtl/regfile_clr_if.sv
// regfile_clr_if: write, read and clear-control bundle of the self-clearing register file.
interface regfile_clr_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             clr;
    logic             busy;
    logic             clr_done;
    logic             wr_drop;
    modport master (output we, wa, wd, ra1, ra2, clr, input rd1, rd2, busy, clr_done, wr_drop);
    modport slave  (input we, wa, wd, ra1, ra2, clr, output rd1, rd2, busy, clr_done, wr_drop);
endinterface

// File: rtl/regfile_clr.sv
// regfile_clr: WIDTH x DEPTH register file, two combinational reads, one write,
// with a sequencer that sweeps every entry to zero after reset or on clr.
module regfile_clr #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    regfile_clr_if.slave  bus
);
    typedef enum logic {CLEAR, READY} state_t;
    state_t           r_state, w_state;
    logic [AW-1:0]    r_cnt, w_cnt;
    logic             r_busy, r_clr_done, r_wr_drop;
    logic             w_clr_done, w_wr_drop, w_last, w_wr_ok;
    logic [WIDTH-1:0] r_rf [DEPTH];

    assign w_last  = r_cnt == AW'(DEPTH - 1);
    assign w_wr_ok = bus.we && !(ZERO_REG != 0 && bus.wa == '0);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_clr_done = 1'b0;
        w_wr_drop  = 1'b0;
        if (r_state == CLEAR) begin
            w_cnt      = w_last ? '0 : r_cnt + 1'b1;
            w_state    = w_last ? READY : CLEAR;
            w_clr_done = w_last;
            w_wr_drop  = bus.we;
        end else if (bus.clr) begin
            w_state = CLEAR;
            w_cnt   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_clr_done <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_busy     <= w_state == CLEAR;
            r_clr_done <= w_clr_done;
            r_wr_drop  <= w_wr_drop;
        end
    end

    // The array is left untouched while reset is held; the sweep owns it in CLEAR.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            if (r_state == CLEAR)
                r_rf[r_cnt] <= '0;
            else if (w_wr_ok)
                r_rf[bus.wa] <= bus.wd;
        end
    end

    assign bus.rd1 = (r_busy || (ZERO_REG != 0 && bus.ra1 == '0)) ? '0 :
                     (BYPASS != 0 && w_wr_ok && bus.wa == bus.ra1) ? bus.wd : r_rf[bus.ra1];
    assign bus.rd2 = (r_busy || (ZERO_REG != 0 && bus.ra2 == '0)) ? '0 :
                     (BYPASS != 0 && w_wr_ok && bus.wa == bus.ra2) ? bus.wd : r_rf[bus.ra2];
    assign bus.busy     = r_busy;
    assign bus.clr_done = r_clr_done;
    assign bus.wr_drop  = r_wr_drop;
endmodule

// File: doc/regfile_clr.md
# regfile_clr

Parametrised successor to the datapath register file. It provides WIDTH×DEPTH storage with two combinational read ports and one synchronous write port. An optional register-0-hardwired-zero mode and optional write-to-read bypass are included for pipelined datapaths. A built-in clear sequencer zeroes every entry after reset or on request, and reports its progress through `busy` and `clr_done`.

## Interface
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: number of registers; power of two, ≥2.
- `AW`, $clog2(DEPTH): address width.
- `ZERO_REG`, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.
- `BYPASS`, 1: 1 = a read of the address being written in the same cycle returns `wd`; 0 = it returns the stored (old) value.

- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: reset is synchronous and active-low; sampled on rising `clk`.
- `we` input 1: write enable.
- `wa` input AW: write address.
- `wd` input WIDTH: write data.
- `ra1`, `ra2` input AW: read addresses.
- `rd1`, `rd2` output WIDTH: combinational read data.
- `clr` input 1: single-cycle request to re-clear all entries.
- `busy` output 1: registered; 1 while the clear sequencer runs.
- `clr_done` output 1: registered; one-cycle pulse when a clear completes.
- `wr_drop` output 1: registered; one-cycle pulse when a write was discarded because `busy` was 1.

## Operation
- The FSM has two states, CLEAR and READY.
- Reset (`reset`=0 at an edge):
  - state←CLEAR, cnt←0.
  - `busy`←1, `clr_done`←0, `wr_drop`←0.
  - Array contents are not modified during reset cycles.
- CLEAR, each edge with `reset`=1:
  - rf[cnt]←0 and cnt←cnt+1.
  - When cnt==DEPTH-1: state←READY, `busy`←0, `clr_done`←1 for exactly one cycle, cnt←0.
- READY:
  - `we`=1 at an edge writes rf[wa]←wd.
  - If ZERO_REG=1 and wa==0, the write is silently ignored; no `wr_drop`.
- `clr`=1 in READY at an edge:
  - Any simultaneous write is still performed at that edge.
  - state←CLEAR, cnt←0, `busy`←1 from the next cycle.
- `clr` in CLEAR is ignored. The sweep neither restarts nor extends.
- `we`=1 while `busy`=1: no array update; `wr_drop`←1 at that edge, cleared the following edge unless repeated.
- Reads, combinational:
  - `busy`=1 → rd=0.
  - Else if ZERO_REG=1 and ra==0 → rd=0.
  - Else if BYPASS=1 and we=1 and wa==ra (and not the ZERO_REG=1 / wa==0 case) → rd=wd.
  - Otherwise → rd=rf[ra].
- Both read ports are independent and may address the same register.
- Width rules:
  - Addresses are used exactly; no wrap, because DEPTH=2^AW.
  - cnt is AW bits; the terminal test is cnt==DEPTH-1, not overflow.

## Timing
- Clear latency: `busy` deasserts exactly DEPTH edges after the first edge with `reset`=1.
  - With defaults, `reset` released before edge 0 → edges 0..31 clear, `busy`=0 and `clr_done`=1 after edge 31.
- `clr` latency: `clr` sampled at edge N → `busy`=1 after N, `clr_done` pulse after edge N+DEPTH, READY writes accepted from edge N+DEPTH+1.
- Write-to-read:
  - With BYPASS=1, same cycle (0 latency).
  - With BYPASS=0, new data visible the cycle after the edge.
- Reset asserted mid-CLEAR restarts the sweep at cnt=0 once released. A full DEPTH-cycle clear is required again.
- Reset asserted in READY with partial contents → CLEAR again; contents remain invalid (reads 0) until the sweep completes.
- `clr_done` and `wr_drop` are never both driven by the same event. They may be 1 in the same cycle only if a write is dropped on the final CLEAR edge.

## Test plan
- Reset clear, defaults: hold `reset`=0 3 cycles, release.
  - `busy`=1 for 32 cycles; `clr_done` pulses once after the 32nd edge.
  - All rd1/rd2 then read 0 for addresses 0..31.
- Write/read, BYPASS=1: write 0xDEADBEEF to r5 while ra1=5.
  - rd1=0xDEADBEEF in the same cycle.
  - Next cycle with we=0, rd1 is still 0xDEADBEEF.
  - With BYPASS=0, rd1 shows the old value (0) during the write cycle and 0xDEADBEEF after.
- Zero register: write 0x12345678 to r0 with ZERO_REG=1.
  - rd=0, no bypass, no `wr_drop`.
  - With ZERO_REG=0, the same write gives rd=0x12345678.
- Dropped write during clear: pulse `we` with wa=3, wd=0xA5 at CLEAR cycle 10.
  - `wr_drop`=1 for one cycle.
  - After `clr_done`, r3 reads 0.
- Re-clear with simultaneous write: in READY, fill r1..r31 with the index value.
  - Assert `clr` and `we` (wa=7, wd=0xFF) on the same edge.
  - `busy` for exactly DEPTH cycles; then all registers read 0.
  - A second `clr` mid-sweep does not extend the sweep.
- Reset mid-clear: assert `reset`=0 at CLEAR cycle 20 for 1 cycle.
  - After release, `busy` stays 1 for a further full 32 cycles.
  - Exactly one `clr_done` pulse occurs in total.
